// File: rtl/bus_lfsr_seq.sv
`default_nettype none
// ============================================================================
// Module   : bus_lfsr_seq
// Purpose  : Bus-addressed bank of independent LFSR sequence channels with
//            serial read-back of each channel's MSB and per-channel wrap pulse.
// Revision : 1.0
// ============================================================================
module bus_lfsr_seq #(
   parameter int              WIDTH    = 6,
   parameter int              CHANNELS = 2,
   parameter logic [WIDTH-1:0] TAPS    = 6'b110000,
   parameter logic [WIDTH-1:0] SEED    = 6'b000001,
   parameter logic [1:0]       BASE    = 2'b01
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sser,
   input  logic [13:4]         ba,
   input  logic                br_w,
   output logic                sdrd,
   output logic                sdrd_oe,
   output logic [CHANNELS-1:0] wrap
);

   localparam logic [2:0] CMD_STEP  = 3'b000;
   localparam logic [2:0] CMD_CLEAR = 3'b010;

   logic [CHANNELS-1:0][WIDTH-1:0] state_q, state_d;
   logic [CHANNELS-1:0]            wrap_q,  wrap_d;
   logic                           sdrd_q,  sdrd_oe_q;
   logic                           access_ok;
   logic                           sel_msb;

   assign access_ok = !sser && (ba[13:12] == BASE) && br_w &&
                      ({1'b0, ba[11:8]} < 5'(CHANNELS));

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         logic [WIDTH-1:0] cur, nxt, upd;
         logic             hit, advance;

         always_comb begin
            cur     = state_q[i];
            nxt     = {cur[WIDTH-2:0], ^(cur & TAPS)};
            hit     = access_ok && (ba[11:8] == 4'(i));
            upd     = cur;
            advance = 1'b0;
            // MATCH commands compare the low three state bits against ba[6:4]
            if (ba[7]) begin
               if (cur[2:0] == ba[6:4]) begin
                  upd     = nxt;
                  advance = 1'b1;
               end else begin
                  upd = SEED;
               end
            end else if (ba[6:4] == CMD_STEP) begin
               upd     = nxt;
               advance = 1'b1;
            end else if (ba[6:4] == CMD_CLEAR) begin
               upd = SEED;
            end
            if (upd == '0) begin
               upd = SEED;
            end
         end

         assign state_d[i] = hit ? upd : cur;
         assign wrap_d[i]  = hit && advance && (upd == SEED);
      end
   endgenerate

   always_comb begin
      sel_msb = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (ba[11:8] == 4'(c)) begin
            sel_msb = state_q[c][WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= {CHANNELS{SEED}};
         wrap_q    <= '0;
         sdrd_q    <= 1'b0;
         sdrd_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrap_q    <= wrap_d;
         sdrd_q    <= access_ok & sel_msb;
         sdrd_oe_q <= access_ok;
      end
   end

   assign sdrd    = sdrd_q;
   assign sdrd_oe = sdrd_oe_q;
   assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_lfsr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_lfsr_seq
// Purpose  : Directed self-checking bench for bus_lfsr_seq (default and 8-bit).
// Revision : 1.0
// ============================================================================
module tb_bus_lfsr_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sser = 1'b1;
   logic [13:4] ba = '0;
   logic        br_w = 1'b0;
   logic        sdrd, sdrd_oe;
   logic [1:0]  wrap;
   logic        sdrd8, sdrd_oe8;
   logic [3:0]  wrap8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_lfsr_seq dut (
      .clk(clk), .rst(rst), .sser(sser), .ba(ba), .br_w(br_w),
      .sdrd(sdrd), .sdrd_oe(sdrd_oe), .wrap(wrap)
   );

   bus_lfsr_seq #(
      .WIDTH(8), .CHANNELS(4), .TAPS(8'b10111000), .SEED(8'h01), .BASE(2'b01)
   ) dut8 (
      .clk(clk), .rst(rst), .sser(sser), .ba(ba), .br_w(br_w),
      .sdrd(sdrd8), .sdrd_oe(sdrd_oe8), .wrap(wrap8)
   );

   function automatic logic [5:0] next6(input logic [5:0] s);
      return {s[4:0], ^(s & 6'b110000)};
   endfunction

   task automatic bus(input logic s, input logic [1:0] win, input logic [3:0] ch,
                      input logic [3:0] cmd, input logic rw);
      sser = s;
      ba   = {win, ch, cmd};
      br_w = rw;
   endtask

   task automatic idle();
      sser = 1'b1;
      ba   = '0;
      br_w = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      n_checks++; if (sdrd_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", sdrd_oe); end
      n_checks++; if (sdrd !== 1'b0) begin n_fail++; $display("FAIL reset_sdrd got %b want 0", sdrd); end
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL reset_wrap got %b want 00", wrap); end
      n_checks++; if (dut.state_q[0] !== 6'b000001) begin n_fail++; $display("FAIL reset_state0 got %b want 000001", dut.state_q[0]); end
      n_checks++; if (dut.state_q[1] !== 6'b000001) begin n_fail++; $display("FAIL reset_state1 got %b want 000001", dut.state_q[1]); end
      rst = 1'b0;
   endtask

   task automatic test_step();
      bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b1);
      tick();
      n_checks++; if (sdrd_oe !== 1'b1) begin n_fail++; $display("FAIL step_oe got %b want 1", sdrd_oe); end
      n_checks++; if (sdrd !== 1'b0) begin n_fail++; $display("FAIL step_sdrd got %b want 0", sdrd); end
      n_checks++; if (dut.state_q[0] !== 6'b000010) begin n_fail++; $display("FAIL step_state0 got %b want 000010", dut.state_q[0]); end
      n_checks++; if (dut.state_q[1] !== 6'b000001) begin n_fail++; $display("FAIL step_state1 got %b want 000001", dut.state_q[1]); end
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL step_wrap got %b want 00", wrap); end
      idle();
      tick();
      n_checks++; if (sdrd_oe !== 1'b0 || sdrd !== 1'b0) begin n_fail++; $display("FAIL step_idle_oe got oe=%b sdrd=%b want 0/0", sdrd_oe, sdrd); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ref_s;
      logic       exp_msb;
      int         wraps, wrap_at;
      ref_s   = 6'b000001;
      wraps   = 0;
      wrap_at = 0;
      for (int k = 1; k <= 63; k++) begin
         bus(1'b0, 2'b01, 4'd1, 4'b0000, 1'b1);
         exp_msb = ref_s[5];
         ref_s   = next6(ref_s);
         tick();
         n_checks++; if (sdrd_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_oe step %0d got %b want 1", k, sdrd_oe); end
         n_checks++; if (sdrd !== exp_msb) begin n_fail++; $display("FAIL b2b_sdrd step %0d got %b want %b", k, sdrd, exp_msb); end
         if (wrap[1] === 1'b1) begin
            wraps++;
            wrap_at = k;
         end
      end
      n_checks++; if (dut.state_q[1] !== 6'b000001) begin n_fail++; $display("FAIL b2b_state1 got %b want 000001", dut.state_q[1]); end
      n_checks++; if (wraps !== 1) begin n_fail++; $display("FAIL b2b_wrap_count got %0d want 1", wraps); end
      n_checks++; if (wrap_at !== 63) begin n_fail++; $display("FAIL b2b_wrap_at got %0d want 63", wrap_at); end
      idle();
      tick();
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL b2b_wrap_after got %b want 00", wrap); end
   endtask

   task automatic test_peek_clear();
      bus(1'b0, 2'b01, 4'd0, 4'b0001, 1'b1);
      tick();
      n_checks++; if (dut.state_q[0] !== 6'b000010 || sdrd_oe !== 1'b1) begin n_fail++; $display("FAIL peek got state=%b oe=%b want 000010/1", dut.state_q[0], sdrd_oe); end
      bus(1'b0, 2'b01, 4'd0, 4'b0101, 1'b1);
      tick();
      n_checks++; if (dut.state_q[0] !== 6'b000010) begin n_fail++; $display("FAIL peek_alias got %b want 000010", dut.state_q[0]); end
      bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b1);
      tick();
      bus(1'b0, 2'b01, 4'd0, 4'b0010, 1'b1);
      tick();
      n_checks++; if (dut.state_q[0] !== 6'b000001) begin n_fail++; $display("FAIL clear_state got %b want 000001", dut.state_q[0]); end
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL clear_wrap got %b want 00", wrap); end
   endtask

   task automatic test_match();
      bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b1);
      tick();
      bus(1'b0, 2'b01, 4'd0, 4'b1010, 1'b1);
      tick();
      n_checks++; if (dut.state_q[0] !== 6'b000100) begin n_fail++; $display("FAIL match_hit got %b want 000100", dut.state_q[0]); end
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL match_hit_wrap got %b want 00", wrap); end
      bus(1'b0, 2'b01, 4'd0, 4'b1111, 1'b1);
      tick();
      n_checks++; if (dut.state_q[0] !== 6'b000001) begin n_fail++; $display("FAIL match_miss got %b want 000001", dut.state_q[0]); end
      n_checks++; if (wrap[0] !== 1'b0) begin n_fail++; $display("FAIL match_miss_wrap got %b want 0", wrap[0]); end
   endtask

   task automatic test_unqualified();
      for (int p = 0; p < 4; p++) begin
         case (p)
            0: bus(1'b1, 2'b01, 4'd0, 4'b0000, 1'b1);
            1: bus(1'b0, 2'b10, 4'd0, 4'b0000, 1'b1);
            2: bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b0);
            default: bus(1'b0, 2'b01, 4'd5, 4'b0000, 1'b1);
         endcase
         tick();
         n_checks++; if (sdrd_oe !== 1'b0 || sdrd !== 1'b0) begin n_fail++; $display("FAIL unq_oe pattern %0d got oe=%b sdrd=%b want 0/0", p, sdrd_oe, sdrd); end
         n_checks++; if (dut.state_q[0] !== 6'b000001 || dut.state_q[1] !== 6'b000001) begin n_fail++; $display("FAIL unq_state pattern %0d got %b/%b want 000001/000001", p, dut.state_q[0], dut.state_q[1]); end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 10; k++) begin
         bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b1);
         tick();
      end
      bus(1'b0, 2'b01, 4'd0, 4'b0000, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      n_checks++; if (dut.state_q[0] !== 6'b000001) begin n_fail++; $display("FAIL rst_mid_state got %b want 000001", dut.state_q[0]); end
      n_checks++; if (sdrd_oe !== 1'b0 || sdrd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe got oe=%b sdrd=%b want 0/0", sdrd_oe, sdrd); end
      n_checks++; if (wrap !== 2'b00) begin n_fail++; $display("FAIL rst_mid_wrap got %b want 00", wrap); end
   endtask

   task automatic test_period8();
      int cnt [4];
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      for (int k = 0; k < 255; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (k == 254 && c == 0) begin
               n_checks++; if (dut8.state_q[0] === 8'h01) begin n_fail++; $display("FAIL p8_early_seed got %h want not 01", dut8.state_q[0]); end
            end
            bus(1'b0, 2'b01, 4'(c), 4'b0000, 1'b1);
            tick();
            for (int w = 0; w < 4; w++) if (wrap8[w] === 1'b1) cnt[w]++;
         end
      end
      idle();
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (dut8.state_q[c] !== 8'h01) begin n_fail++; $display("FAIL p8_state ch%0d got %h want 01", c, dut8.state_q[c]); end
         n_checks++; if (cnt[c] !== 1) begin n_fail++; $display("FAIL p8_wraps ch%0d got %0d want 1", c, cnt[c]); end
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_back_to_back();
      test_peek_clear();
      test_match();
      test_unqualified();
      test_reset_mid();
      test_period8();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_lfsr_seq.md
BUS_LFSR_SEQ -- requirements
Module: bus_lfsr_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 6, giving the per-channel sequence state width (range 3..16).
REQ-002 The module SHALL have parameter CHANNELS, default 2, giving the number of independent sequence channels (range 1..16).
REQ-003 The module SHALL have parameter TAPS, default 6'b110000, a WIDTH-bit feedback mask where bit i set means state[i] feeds the XOR.
REQ-004 The module SHALL have parameter SEED, default 6'b000001, a WIDTH-bit nonzero value loaded at reset and by CLEAR.
REQ-005 The module SHALL have parameter BASE, default 2'b01, the value of ba[13:12] that selects this block.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The module SHALL have port sser, input, 1 bit: active-low bus select.
REQ-009 The module SHALL have port ba, input, 10 bits (ba[13:4]): bus address; ba[13:12] is the window, ba[11:8] the channel, ba[7:4] the command.
REQ-010 The module SHALL have port br_w, input, 1 bit: high means read cycle.
REQ-011 The module SHALL have port sdrd, output, 1 bit: serial read data.
REQ-012 The module SHALL have port sdrd_oe, output, 1 bit: high when sdrd is valid and driven.
REQ-013 The module SHALL have port wrap, output, CHANNELS bits: per-channel one-cycle pulse on sequence wrap.

Function
REQ-014 An access SHALL be qualified in a cycle when sser=0, ba[13:12]=BASE, br_w=1 and ba[11:8]<CHANNELS; any other cycle SHALL have no effect on channel state.
REQ-015 A qualified access SHALL act on channel ch=ba[11:8] only; all other channels SHALL hold their state.
REQ-016 The step function SHALL be next(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
REQ-017 Command 4'b0000 STEP SHALL set state[ch] <= next(state[ch]).
REQ-018 Command 4'b0001 PEEK SHALL leave state[ch] unchanged.
REQ-019 Command 4'b0010 CLEAR SHALL set state[ch] <= SEED.
REQ-020 Commands 4'b1nnn MATCH SHALL set state[ch] <= next(state[ch]) when state[ch][2:0]=nnn, and SEED otherwise.
REQ-021 Commands 4'b0011 through 4'b0111 SHALL be treated as PEEK.
REQ-022 If any update would produce all-zero state, the channel SHALL load SEED instead (lock-up guard).
REQ-023 For each qualified access in cycle N, cycle N+1 SHALL have sdrd_oe=1 and sdrd equal to bit WIDTH-1 of the pre-update state[ch] sampled in cycle N.
REQ-024 In every cycle not following a qualified access, sdrd_oe SHALL be 0 and sdrd SHALL be 0.
REQ-025 Back-to-back qualified accesses SHALL each be serviced, one per cycle, at full rate with no stall.
REQ-026 wrap[ch] SHALL pulse for exactly one cycle (cycle N+1) when a STEP or successful MATCH in cycle N makes state[ch]=SEED; CLEAR SHALL NOT raise wrap.
REQ-027 A qualified access in the same cycle as rst=1 SHALL be ignored.

Reset
REQ-028 With rst=1 at a clock edge, every channel SHALL load SEED and sdrd, sdrd_oe and wrap SHALL all go to 0.
REQ-029 Reset applied mid-sequence SHALL discard any pending sdrd_oe or wrap pulse in the following cycle.

Verification
REQ-030 Defaults, reset, then STEP on ch0 -> next cycle sdrd_oe=1, sdrd=0, state0=6'b000010; state1 stays 6'b000001.
REQ-031 63 consecutive STEPs on ch1 -> state1 returns to 6'b000001, wrap[1] pulses exactly once (after the 63rd), and sdrd_oe stays high throughout.
REQ-032 State0=6'b000010, MATCH nnn=010 -> state0=6'b000100; then MATCH nnn=111 -> state0=6'b000001 with wrap[0]=0.
REQ-033 Unqualified cycles (sser=1, ba[13:12]=2'b10, br_w=0, ch=5 with CHANNELS=2) -> no state change and sdrd_oe=0.
REQ-034 rst=1 in the same cycle as STEP after 10 steps -> state=SEED, sdrd_oe=0 in the next cycle.
REQ-035 WIDTH=8, TAPS=8'b10111000, CHANNELS=4 -> each channel has period 255, with one wrap pulse per period.
